// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the high-resolution PWM bank: register map and
// the per-channel compare write-select type.
package pwm_bank_pkg;

  // Register map: period at 0, then one lo/hi compare pair per channel.
  localparam logic [4:0] ADDR_PRD       = 5'd0;
  localparam int         ADDR_CH_BASE   = 1;
  localparam int         ADDR_CH_STRIDE = 2;

  // Write selects for one channel's compare pair.
  typedef struct packed {
    logic wr_lo;
    logic wr_hi;
  } chan_cmp_wr_t;

  // True when addr selects the lo (hi=0) or hi (hi=1) compare of channel ch.
  // Compared at 32 bits so the top channels never alias onto low addresses.
  function automatic logic is_cmp_addr(input logic [4:0] addr, input int ch, input logic hi);
    int target;
    target = ADDR_CH_BASE + ADDR_CH_STRIDE * ch + (hi ? 1 : 0);
    return ({27'd0, addr} == target);
  endfunction

endpackage

// File: rtl/pwm_hr_chan.sv
// One PWM channel: shadow/active compare pair and a registered vector of
// sub-clock output slots evaluated against the shared coarse timebase.
module pwm_hr_chan
  import pwm_bank_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int HRBITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_i,
  input  logic                     load_i,
  input  chan_cmp_wr_t             wr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [WIDTH-HRBITS-1:0]  tb_i,
  output logic [2**HRBITS-1:0]     slots_o
);

  localparam int SLOTS = 2**HRBITS;

  logic [WIDTH-1:0] lo_sh_q, hi_sh_q;
  logic [WIDTH-1:0] lo_act_q, hi_act_q;
  logic [SLOTS-1:0] slots_q, slots_d;
  logic [WIDTH-1:0] c_s;

  // Shadow compares take bus writes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_sh_q <= '0;
      hi_sh_q <= '0;
    end else begin
      if (wr_i.wr_lo) lo_sh_q <= wr_data_i;
      if (wr_i.wr_hi) hi_sh_q <= wr_data_i;
    end
  end

  // Active compares follow the shadows only at load events (pre-write value).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_act_q <= '0;
      hi_act_q <= '0;
    end else if (load_i) begin
      lo_act_q <= lo_sh_q;
      hi_act_q <= hi_sh_q;
    end
  end

  // Evaluate every sub-clock slot's fine count against the active window.
  always_comb begin
    slots_d = '0;
    c_s     = '0;
    for (int k = 0; k < SLOTS; k++) begin
      c_s = {tb_i, k[HRBITS-1:0]};
      if (!run_i) begin
        slots_d[k] = 1'b0;
      end else if (lo_act_q < hi_act_q) begin
        slots_d[k] = (c_s >= lo_act_q) && (c_s < hi_act_q);
      end else if (lo_act_q > hi_act_q) begin
        slots_d[k] = (c_s >= lo_act_q) || (c_s < hi_act_q);
      end else begin
        slots_d[k] = 1'b0;
      end
    end
  end

  // Register the slot vector so the output is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slots_q <= '0;
    else     slots_q <= slots_d;
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of high-resolution PWM channels sharing one down-counting coarse
// timebase, a period register with shadow/active pair and a sync pulse.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int HRBITS = 3,
  parameter int NCH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr_en,
  input  logic [4:0]                 wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       period_sync,
  output logic [NCH*(2**HRBITS)-1:0] pwm_d
);

  localparam int TBW   = WIDTH - HRBITS;
  localparam int SLOTS = 2**HRBITS;

  logic [TBW-1:0] tb_q, tb_d;
  logic [TBW-1:0] prd_sh_q, prd_act_q, prd_act_d;
  logic           sync_q, sync_d;
  logic           load_s;
  logic           prd_wr_s;
  chan_cmp_wr_t   ch_wr_s [NCH];

  // A disabled bank loads every cycle, so the first enabled cycle also loads.
  assign load_s   = !en || (tb_q == '0);
  assign prd_wr_s = wr_en && (wr_addr == ADDR_PRD);

  // Timebase next state; reload takes the period that becomes active now.
  always_comb begin
    prd_act_d = prd_act_q;
    tb_d      = tb_q;
    sync_d    = 1'b0;
    if (load_s) prd_act_d = prd_sh_q;
    else        prd_act_d = prd_act_q;
    if (!en) begin
      tb_d   = '0;
      sync_d = 1'b0;
    end else if (tb_q == '0) begin
      tb_d   = prd_act_d;
      sync_d = 1'b1;
    end else begin
      tb_d   = tb_q - TBW'(1);
      sync_d = 1'b0;
    end
  end

  // Timebase, period registers and sync pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_q      <= '0;
      prd_sh_q  <= '1;
      prd_act_q <= '1;
      sync_q    <= 1'b0;
    end else begin
      tb_q      <= tb_d;
      prd_act_q <= prd_act_d;
      sync_q    <= sync_d;
      if (prd_wr_s) prd_sh_q <= wr_data[TBW-1:0];
    end
  end

  // Decode compare writes to per-channel selects; unmapped addresses hit nothing.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_wr_s[i] = '0;
      if (wr_en) begin
        ch_wr_s[i].wr_lo = is_cmp_addr(wr_addr, i, 1'b0);
        ch_wr_s[i].wr_hi = is_cmp_addr(wr_addr, i, 1'b1);
      end else begin
        ch_wr_s[i] = '0;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pwm_hr_chan #(
      .WIDTH  (WIDTH),
      .HRBITS (HRBITS)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .run_i     (en),
      .load_i    (load_s),
      .wr_i      (ch_wr_s[i]),
      .wr_data_i (wr_data),
      .tb_i      (tb_q),
      .slots_o   (pwm_d[i*SLOTS +: SLOTS])
    );
  end

  assign period_sync = sync_q;

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 18, meaning full-resolution compare/period width in fine ticks.
REQ-002 SHALL have parameter HRBITS, default 3, meaning number of sub-clock (high-resolution) bits; each clock carries 2^HRBITS output slots.
REQ-003 SHALL have parameter NCH, default 4, meaning number of PWM channels (1..16).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  run enable for the shared timebase.
REQ-007 SHALL have port wr_en  input  1  register write strobe.
REQ-008 SHALL have port wr_addr  input  5  register address.
REQ-009 SHALL have port wr_data  input  WIDTH  register write data.
REQ-010 SHALL have port period_sync  output  1  one-cycle pulse per period start.
REQ-011 SHALL have port pwm_d  output  NCH*2^HRBITS  per-channel slot vectors; channel i at bits [i*2^HRBITS +: 2^HRBITS], bit k = slot k.

Function
REQ-012 SHALL keep a coarse timebase tb of WIDTH-HRBITS bits counting down by 1 per clock while en=1, reloading to active period register prd when tb==0.
REQ-013 SHALL define fine count c = tb*2^HRBITS + k for slot k.
REQ-014 SHALL map addresses: 0 = period (wr_data[WIDTH-HRBITS-1:0]), 1+2i = cmp_lo channel i, 2+2i = cmp_hi channel i; addresses >= 2*NCH+1 SHALL be ignored.
REQ-015 SHALL write wr_data into a shadow register on wr_en; active registers SHALL only change at a load event.
REQ-016 SHALL create a load event in every cycle where en=1 and tb==0, and every cycle where en=0; load copies all shadow registers to active.
REQ-017 SHALL, on a write and load in the same cycle, update the shadow with new data and load the pre-write shadow value into active.
REQ-018 SHALL drive slot k of channel i high iff: cmp_lo<cmp_hi and cmp_lo<=c<cmp_hi; or cmp_lo>cmp_hi and (c>=cmp_lo or c<cmp_hi); cmp_lo==cmp_hi gives constant low.
REQ-019 SHALL register pwm_d: value in cycle n+1 reflects tb and active compares of cycle n (latency 1).
REQ-020 SHALL, for compares using the tb==0 cycle, evaluate against the old active set; the new set applies from the reload cycle onward.
REQ-021 SHALL pulse period_sync high for exactly one cycle, the cycle after en=1 and tb==0.
REQ-022 SHALL, while en=0, hold tb at 0 and drive all pwm_d bits and period_sync low (registered, latency 1).
REQ-023 SHALL, when en rises, treat the first enabled cycle as tb==0: load event, reload tb=prd next cycle.
REQ-024 SHALL use unsigned compare at full WIDTH with no wrap arithmetic; period of 0 gives a 1-clock period.

Reset
REQ-025 SHALL, while rst=1, set tb=0, period shadow/active = 2^(WIDTH-HRBITS)-1, all cmp_lo/cmp_hi shadow/active = 0, pwm_d=0, period_sync=0.
REQ-026 SHALL abort any period on rst assertion mid-operation, with no output glitch high after rst rises.

Structure
REQ-027 SHALL place register address constants (ADDR_PRD, channel base/stride) and a channel-compare struct type in shared package pwm_bank_pkg.
REQ-028 SHALL instantiate NCH copies of sub-module pwm_hr_chan (shadow/active compare pair plus slot-vector compare and output register); timebase, decode and period_sync reside in pwm_bank.

Verification
REQ-029 SHALL cover: defaults, HRBITS=3, prd=9, ch0 lo=0x10 hi=0x30, en=1 -> period_sync every 10 clocks; ch0 high for exactly 32 slots per period, edges at c=0x30 and c=0x10.
REQ-030 SHALL cover: ch1 lo=0x2D hi=0x13 (wrap mode), prd=9 -> ch1 high for c>=0x2D or c<0x13; partial slot vectors 8'b1110_0000 at tb=5 and 8'b0000_0111 at tb=2 (bit k = slot k).
REQ-031 SHALL cover: cmp_hi write mid-period -> pwm_d unchanged until cycle after next tb==0 reload; write coincident with tb==0 -> applies one period later.
REQ-032 SHALL cover: lo==hi=0x20 -> channel constant low; lo=0 hi=prd*8+8 -> constant high.
REQ-033 SHALL cover: en dropped mid-period -> pwm_d low 1 cycle later, tb=0; en re-raised -> period_sync 1 cycle later, full period from prd.
REQ-034 SHALL cover: rst asserted mid-period -> pwm_d=0 and period_sync=0 immediately, period register reads back 2^15-1 behaviour (period 32768 clocks).
